// File: rtl/reg_file_dp.sv
// Dual-read, single-write register file with byte-enabled writes, write-first
// read bypass, out-of-range detection and a sequential clear-all sweep.
module reg_file_dp #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WrEn,
    input  logic [ADDR_WIDTH-1:0]   WrAddr,
    input  logic [DATA_WIDTH-1:0]   WrData,
    input  logic [DATA_WIDTH/8-1:0] WrBe,
    input  logic                    RdEnA,
    input  logic [ADDR_WIDTH-1:0]   RdAddrA,
    input  logic                    RdEnB,
    input  logic [ADDR_WIDTH-1:0]   RdAddrB,
    output logic [DATA_WIDTH-1:0]   RdDataA,
    output logic                    RdValidA,
    output logic [DATA_WIDTH-1:0]   RdDataB,
    output logic                    RdValidB,
    input  logic                    Clr,
    output logic                    Busy,
    output logic                    AddrErr
);

    localparam int LANES = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wrReq, wrAccept, rdReqA, rdReqB;
    logic                  wrInRange, inRangeA, inRangeB;
    logic [DATA_WIDTH-1:0] wrBase, wrMerged, rdValA, rdValB;

    // A write is only considered when idle and not overtaken by a clear; reads
    // are serviced in the Clr cycle too and therefore see pre-clear contents.
    always_comb begin
        wrInRange = 32'(WrAddr)  < DEPTH;
        inRangeA  = 32'(RdAddrA) < DEPTH;
        inRangeB  = 32'(RdAddrB) < DEPTH;
        wrReq     = WrEn && !Busy && !Clr;
        wrAccept  = wrReq && wrInRange;
        rdReqA    = RdEnA && !Busy;
        rdReqB    = RdEnB && !Busy;

        wrBase   = wrInRange ? mem[WrAddr] : '0;
        wrMerged = wrBase;
        for (int i = 0; i < LANES; i++) begin
            if (WrBe[i]) begin
                wrMerged[8*i +: 8] = WrData[8*i +: 8];
            end
        end

        rdValA = '0;
        if (inRangeA) begin
            rdValA = (wrAccept && RdAddrA == WrAddr) ? wrMerged : mem[RdAddrA];
        end
        rdValB = '0;
        if (inRangeB) begin
            rdValB = (wrAccept && RdAddrB == WrAddr) ? wrMerged : mem[RdAddrB];
        end
    end

    // Storage, read registers and the clear FSM share one process because the
    // sweep and normal writes both update the array.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            state    <= IDLE;
            cnt      <= '0;
            Busy     <= 1'b0;
            RdDataA  <= '0;
            RdDataB  <= '0;
            RdValidA <= 1'b0;
            RdValidB <= 1'b0;
            AddrErr  <= 1'b0;
        end else begin
            RdValidA <= rdReqA;
            RdValidB <= rdReqB;
            if (rdReqA) begin
                RdDataA <= rdValA;
            end
            if (rdReqB) begin
                RdDataB <= rdValB;
            end
            AddrErr <= (wrReq && !wrInRange) || (rdReqA && !inRangeA) ||
                       (rdReqB && !inRangeB);

            case (state)
                IDLE: begin
                    if (Clr) begin
                        state <= CLEAR;
                        Busy  <= 1'b1;
                        cnt   <= '0;
                    end else if (wrAccept) begin
                        mem[WrAddr] <= wrMerged;
                    end
                end
                CLEAR: begin
                    mem[cnt] <= '0;
                    if (cnt == LAST) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_file_dp.sv
// Directed bench for reg_file_dp: a default 8-entry instance plus a 6-entry
// instance sharing the same stimulus for the out-of-range cases.
module tb_reg_file_dp;

    logic        CLK;
    logic        RST;
    logic        WrEn;
    logic [2:0]  WrAddr;
    logic [15:0] WrData;
    logic [1:0]  WrBe;
    logic        RdEnA, RdEnB;
    logic [2:0]  RdAddrA, RdAddrB;
    logic [15:0] RdDataA, RdDataB;
    logic        RdValidA, RdValidB;
    logic        Clr, Busy, AddrErr;

    logic [15:0] rdDataA6, rdDataB6;
    logic        rdValidA6, rdValidB6, busy6, addrErr6;

    int checkCount;
    int errorCount;
    int busyCycles;

    reg_file_dp dut (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .WrBe(WrBe), .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdEnB(RdEnB),
        .RdAddrB(RdAddrB), .RdDataA(RdDataA), .RdValidA(RdValidA),
        .RdDataB(RdDataB), .RdValidB(RdValidB), .Clr(Clr), .Busy(Busy),
        .AddrErr(AddrErr)
    );

    reg_file_dp #(.DATA_WIDTH(16), .DEPTH(6), .ADDR_WIDTH(3)) dut6 (
        .CLK(CLK), .RST(RST), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
        .WrBe(WrBe), .RdEnA(RdEnA), .RdAddrA(RdAddrA), .RdEnB(RdEnB),
        .RdAddrB(RdAddrB), .RdDataA(rdDataA6), .RdValidA(rdValidA6),
        .RdDataB(rdDataB6), .RdValidB(rdValidB6), .Clr(Clr), .Busy(busy6),
        .AddrErr(addrErr6)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Drive one cycle of requests, let the edge capture them, then go quiet.
    task automatic applyStimulus(input logic wrEn, input logic [2:0] wrAddr,
                                 input logic [15:0] wrData, input logic [1:0] wrBe,
                                 input logic rdEnA, input logic [2:0] rdAddrA,
                                 input logic rdEnB, input logic [2:0] rdAddrB,
                                 input logic clr);
        WrEn = wrEn; WrAddr = wrAddr; WrData = wrData; WrBe = wrBe;
        RdEnA = rdEnA; RdAddrA = rdAddrA; RdEnB = rdEnB; RdAddrB = rdAddrB;
        Clr = clr;
        tick();
        WrEn = 1'b0; RdEnA = 1'b0; RdEnB = 1'b0; Clr = 1'b0; WrBe = 2'b00;
    endtask

    task automatic readBoth(input logic [2:0] addr, input logic [15:0] expected,
                            input string tag);
        applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, addr, 1'b1, addr, 1'b0);
        checkOutput($sformatf("%s_validA%0d", tag, addr), {31'd0, RdValidA}, 32'd1);
        checkOutput($sformatf("%s_dataA%0d", tag, addr), {16'd0, RdDataA}, {16'd0, expected});
        checkOutput($sformatf("%s_dataB%0d", tag, addr), {16'd0, RdDataB}, {16'd0, expected});
    endtask

    task automatic writeEntry(input logic [2:0] addr, input logic [15:0] data,
                              input logic [1:0] be);
        applyStimulus(1'b1, addr, data, be, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0);
    endtask

    initial begin
        logic [15:0] exp6 [6];
        checkCount = 0;
        errorCount = 0;
        RST = 1'b1;
        WrEn = 1'b0; WrAddr = '0; WrData = '0; WrBe = '0;
        RdEnA = 1'b0; RdAddrA = '0; RdEnB = 1'b0; RdAddrB = '0; Clr = 1'b0;

        tick();
        tick();
        checkOutput("rstDataA", {16'd0, RdDataA}, 32'd0);
        checkOutput("rstDataB", {16'd0, RdDataB}, 32'd0);
        checkOutput("rstValidA", {31'd0, RdValidA}, 32'd0);
        checkOutput("rstBusy", {31'd0, Busy}, 32'd0);
        checkOutput("rstAddrErr", {31'd0, AddrErr}, 32'd0);
        RST = 1'b0;
        tick();

        // Basic write then read with one-cycle valid strobe and data hold.
        writeEntry(3'd3, 16'hA5A5, 2'b11);
        readBoth(3'd3, 16'hA5A5, "wr3");
        tick();
        checkOutput("validDrop", {31'd0, RdValidA}, 32'd0);
        checkOutput("dataHold", {16'd0, RdDataA}, 32'h0000A5A5);
        for (int i = 0; i < 8; i++) begin
            if (i != 3) readBoth(3'(i), 16'h0000, "zero");
        end

        // Byte-lane merge and an all-zero enable that must change nothing.
        writeEntry(3'd5, 16'h1234, 2'b11);
        writeEntry(3'd5, 16'hFFFF, 2'b01);
        readBoth(3'd5, 16'h12FF, "be01");
        writeEntry(3'd5, 16'h0000, 2'b00);
        checkOutput("be00Err", {31'd0, AddrErr}, 32'd0);
        readBoth(3'd5, 16'h12FF, "be00");

        // Write-first bypass on both ports, full then partial lanes.
        applyStimulus(1'b1, 3'd2, 16'h0BEE, 2'b11, 1'b1, 3'd2, 1'b1, 3'd2, 1'b0);
        checkOutput("wfDataA", {16'd0, RdDataA}, 32'h00000BEE);
        checkOutput("wfDataB", {16'd0, RdDataB}, 32'h00000BEE);
        checkOutput("wfValidB", {31'd0, RdValidB}, 32'd1);
        applyStimulus(1'b1, 3'd2, 16'h5566, 2'b10, 1'b1, 3'd2, 1'b0, 3'd0, 1'b0);
        checkOutput("wfPartial", {16'd0, RdDataA}, 32'h000055EE);
        readBoth(3'd2, 16'h55EE, "wfStored");

        // Out-of-range on the 6-entry instance; address 7/6 are legal on the 8-entry one.
        applyStimulus(1'b1, 3'd7, 16'hDEAD, 2'b11, 1'b1, 3'd6, 1'b0, 3'd0, 1'b0);
        checkOutput("oorErr6", {31'd0, addrErr6}, 32'd1);
        checkOutput("oorValid6", {31'd0, rdValidA6}, 32'd1);
        checkOutput("oorData6", {16'd0, rdDataA6}, 32'd0);
        checkOutput("inRangeErr8", {31'd0, AddrErr}, 32'd0);
        checkOutput("inRangeData8", {16'd0, RdDataA}, 32'd0);
        tick();
        checkOutput("oorErrPulse", {31'd0, addrErr6}, 32'd0);
        exp6[0] = 16'h0000; exp6[1] = 16'h0000; exp6[2] = 16'h55EE;
        exp6[3] = 16'hA5A5; exp6[4] = 16'h0000; exp6[5] = 16'h12FF;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b1, 3'(i), 1'b0, 3'd0, 1'b0);
            checkOutput($sformatf("oorKeep6_%0d", i), {16'd0, rdDataA6}, {16'd0, exp6[i]});
        end
        readBoth(3'd7, 16'hDEAD, "wr7on8");

        // Clear sweep: Clr beats a concurrent write, same-cycle read sees old data.
        for (int i = 0; i < 8; i++) writeEntry(3'(i), 16'h1100 + 16'(i), 2'b11);
        applyStimulus(1'b1, 3'd0, 16'hFFFF, 2'b11, 1'b1, 3'd4, 1'b0, 3'd0, 1'b1);
        checkOutput("clrBusy", {31'd0, Busy}, 32'd1);
        checkOutput("clrPreRead", {16'd0, RdDataA}, 32'h00001104);
        checkOutput("clrPreValid", {31'd0, RdValidA}, 32'd1);
        busyCycles = 1;
        for (int k = 0; k < 20; k++) begin
            WrEn = 1'b1; WrAddr = 3'd1; WrData = 16'hBEEF; WrBe = 2'b11;
            RdEnA = 1'b1; RdAddrA = 3'd1; Clr = 1'b1;
            tick();
            if (!Busy) break;
            busyCycles++;
            checkOutput("busyNoValid", {31'd0, RdValidA}, 32'd0);
            checkOutput("busyNoErr", {31'd0, AddrErr}, 32'd0);
        end
        WrEn = 1'b0; RdEnA = 1'b0; Clr = 1'b0; WrBe = 2'b00;
        checkOutput("busyLength", busyCycles, 32'd8);
        tick();
        for (int i = 0; i < 8; i++) readBoth(3'(i), 16'h0000, "cleared");

        // Reset during the fourth busy cycle aborts the sweep.
        for (int i = 0; i < 8; i++) writeEntry(3'(i), 16'h2200 + 16'(i), 2'b11);
        applyStimulus(1'b0, 3'd0, 16'h0, 2'b00, 1'b0, 3'd0, 1'b0, 3'd0, 1'b1);
        tick();
        tick();
        tick();
        checkOutput("busyCycle4", {31'd0, Busy}, 32'd1);
        #2 RST = 1'b1;
        #1;
        checkOutput("rstAbortBusy", {31'd0, Busy}, 32'd0);
        @(posedge CLK);
        #3 RST = 1'b0;
        writeEntry(3'd6, 16'h6666, 2'b11);
        readBoth(3'd6, 16'h6666, "postRst");
        for (int i = 0; i < 8; i++) begin
            if (i != 6) readBoth(3'(i), 16'h0000, "rstZero");
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
